// File: rtl/serial_sub_seq.sv
// Sequential WIDTH-bit subtractor: walks the operands two bits per cycle
// through an external 2-bit subtractor stage, rippling the borrow through a register.
module serial_sub_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             borrow_out,
  output logic             zero,
  output logic [1:0]       sub_x,
  output logic [1:0]       sub_y,
  output logic             sub_bin,
  input  logic [1:0]       sub_diff,
  input  logic             sub_bout,
  output logic [1:0]       dbg_state
);

  localparam int NS = WIDTH / 2;
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NS-1:0][1:0]      a_q, a_d;
  logic [NS-1:0][1:0]      b_q, b_d;
  logic [NS-1:0][1:0]      res_q, res_d;
  logic                    brw_q, brw_d;
  logic                    bout_q, bout_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
    end
  end

  // The stage is only driven (and its answer only consumed) while in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    sub_x   = 2'b00;
    sub_y   = 2'b00;
    sub_bin = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          brw_d   = bin_in;
          cnt_d   = '0;
        end
      end
      RUN: begin
        sub_x         = a_q[cnt_q];
        sub_y         = b_q[cnt_q];
        sub_bin       = brw_q;
        res_d[cnt_q]  = sub_diff;
        brw_d         = sub_bout;
        cnt_d         = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          bout_d  = sub_bout;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign result     = res_q;
  assign borrow_out = bout_q;
  assign zero       = (res_q == '0);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_serial_sub_seq.sv
// Bench for serial_sub_seq: directed operand vectors, a 2-bit subtractor model
// on the stage port, and a done-driven scoreboard monitor.
module tb_serial_sub_seq;

  localparam int W = 8;

  // Handshake: start is a request sampled only in IDLE; done is a one-cycle
  // pulse and result/borrow_out/zero are valid whenever done is high.
  typedef struct packed {
    logic [W-1:0] res;
    logic         bout;
    logic [31:0]  done_cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin_in = 1'b0;
  logic         busy, done, borrow_out, zero, sub_bin, sub_bout;
  logic [W-1:0] result;
  logic [1:0]   sub_x, sub_y, sub_diff, dbg_state;
  logic [2:0]   stage_full;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] cyc = '0;

  serial_sub_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin_in(bin_in),
    .busy(busy), .done(done), .result(result), .borrow_out(borrow_out),
    .zero(zero), .sub_x(sub_x), .sub_y(sub_y), .sub_bin(sub_bin),
    .sub_diff(sub_diff), .sub_bout(sub_bout), .dbg_state(dbg_state)
  );

  // External 2-bit stage: a negative 3-bit difference means a borrow.
  assign stage_full = {1'b0, sub_x} - {1'b0, sub_y} - {2'b00, sub_bin};
  assign sub_diff   = stage_full[1:0];
  assign sub_bout   = stage_full[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse; stage port must be quiet outside RUN.
  always @(negedge clk) begin
    if (rst_n && !busy) begin
      check("stage_idle", {27'd0, sub_x, sub_y, sub_bin}, 32'd0);
    end
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", {24'd0, result}, {24'd0, e.res});
        check("borrow_out", {31'd0, borrow_out}, {31'd0, e.bout});
        check("zero", {31'd0, zero}, {31'd0, (e.res == '0)});
        check("done_latency", cyc, e.done_cyc);
      end
    end
  end

  // Done is seen on the 5th negedge after the accepting edge, i.e. 4 cycles later.
  task automatic push_exp(input logic [W-1:0] r, input logic bo, input logic [31:0] acc_cyc);
    exp_t e;
    e.res      = r;
    e.bout     = bo;
    e.done_cyc = acc_cyc + 32'(W / 2);
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                       input logic [W-1:0] r, input logic bo);
    @(negedge clk);
    a = av; b = bv; bin_in = bi; start = 1'b1;
    @(posedge clk);
    #1;
    push_exp(r, bo, cyc);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy && !done && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_timeout", {31'd0, ok}, 32'd1);
    if (!ok) exp_q.delete();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    check("rst_result", {24'd0, result}, 32'd0);
    check("rst_borrow", {31'd0, borrow_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors: a, b, bin_in -> result, borrow_out (hand computed)
    issue(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0); wait_idle();
    issue(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1); wait_idle();
    issue(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0); wait_idle();
    issue(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1); wait_idle();
    issue(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0); wait_idle();
    issue(8'hC3, 8'h3C, 1'b0, 8'h87, 1'b0); wait_idle();
    issue(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1); wait_idle();

    // Result held stable while idle after completion
    repeat (3) @(negedge clk);
    check("hold_result", {24'd0, result}, 32'h0000_00FF);
    check("hold_borrow", {31'd0, borrow_out}, 32'd1);

    // Start re-pulsed during RUN with different operands is ignored
    issue(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
    @(negedge clk);
    a = 8'hFF; b = 8'h00; bin_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);

    // Reset for one edge while cnt = 2 aborts with no done pulse
    issue(8'h33, 8'h11, 1'b0, 8'h22, 1'b0);
    void'(exp_q.pop_back());
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_result", {24'd0, result}, 32'd0);
    check("abort_zero", {31'd0, zero}, 32'd1);
    repeat (8) @(negedge clk);
    issue(8'h33, 8'h11, 1'b0, 8'h22, 1'b0); wait_idle();

    // Start held high: three operations accepted every W/2+2 edges
    @(negedge clk);
    a = 8'h01; b = 8'h02; bin_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    push_exp(8'hFF, 1'b1, cyc);
    push_exp(8'hFF, 1'b1, cyc + 32'(W / 2 + 2));
    push_exp(8'hFF, 1'b1, cyc + 32'(2 * (W / 2 + 2)));
    repeat (2 * (W / 2 + 2)) @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    repeat (8) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
